cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one hold buffer per functional unit, round-robin
// selection of a single registered broadcast per cycle, with squash on flush.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int VAL_W   = 64,
    localparam int SRC_W  = $clog2(NUM_REQ),
    localparam int PCNT_W = $clog2(NUM_REQ + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*VAL_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [VAL_W-1:0]           cdb_value,
    output logic [SRC_W-1:0]           cdb_src,
    output logic [PCNT_W-1:0]          pending_cnt
);

    function automatic logic [PCNT_W-1:0] popcount(input logic [NUM_REQ-1:0] vec);
        logic [PCNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt = cnt + PCNT_W'(vec[i]);
        end
        return cnt;
    endfunction

    logic [NUM_REQ-1:0]             buf_valid_r;
    logic [NUM_REQ-1:0][TAG_W-1:0]  buf_tag_r;
    logic [NUM_REQ-1:0][VAL_W-1:0]  buf_value_r;
    logic [SRC_W-1:0]               rr_ptr_r;
    logic                           cdb_valid_r;
    logic [TAG_W-1:0]               cdb_tag_r;
    logic [VAL_W-1:0]               cdb_value_r;
    logic [SRC_W-1:0]               cdb_src_r;
    logic [PCNT_W-1:0]              pending_cnt_r;

    logic [NUM_REQ-1:0]             grant_s;
    logic                           grant_any_s;
    logic [SRC_W-1:0]               grant_idx_s;
    logic [SRC_W-1:0]               rr_next_s;
    logic [NUM_REQ-1:0]             req_ready_s;
    logic [NUM_REQ-1:0]             accept_s;
    logic [NUM_REQ-1:0]             buf_valid_nxt_s;

    // Round-robin search upward from rr_ptr, wrapping at NUM_REQ-1; first valid buffer wins.
    always_comb begin
        grant_s     = '0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx_v;
            idx_v = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (buf_valid_r[SRC_W'(idx_v)] && !grant_any_s) begin
                grant_any_s                = 1'b1;
                grant_idx_s                = SRC_W'(idx_v);
                grant_s[SRC_W'(idx_v)]     = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Pointer advances past the winner, wrapping explicitly for non-power-of-two NUM_REQ.
    always_comb begin
        rr_next_s = '0;
        if (grant_idx_s == SRC_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + SRC_W'(1);
        end
    end

    // A buffer can take a new result if empty or being drained this cycle; flush blocks all.
    always_comb begin
        req_ready_s     = '0;
        accept_s        = '0;
        buf_valid_nxt_s = buf_valid_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_s[i] = ~flush & (~buf_valid_r[i] | grant_s[i]);
            accept_s[i]    = req_valid[i] & req_ready_s[i];
            if (accept_s[i]) begin
                buf_valid_nxt_s[i] = 1'b1;
            end else if (grant_s[i]) begin
                buf_valid_nxt_s[i] = 1'b0;
            end else begin
                buf_valid_nxt_s[i] = buf_valid_r[i];
            end
        end
    end

    // State update: reset dominates flush, flush dominates normal accept/broadcast.
    always_ff @(posedge clock) begin
        if (!reset) begin
            buf_valid_r   <= '0;
            buf_tag_r     <= '0;
            buf_value_r   <= '0;
            rr_ptr_r      <= '0;
            cdb_valid_r   <= 1'b0;
            cdb_tag_r     <= '0;
            cdb_value_r   <= '0;
            cdb_src_r     <= '0;
            pending_cnt_r <= '0;
        end else if (flush) begin
            buf_valid_r   <= '0;
            cdb_valid_r   <= 1'b0;
            pending_cnt_r <= '0;
        end else begin
            buf_valid_r   <= buf_valid_nxt_s;
            pending_cnt_r <= popcount(buf_valid_nxt_s);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_s[i]) begin
                    buf_tag_r[i]   <= req_tag[i*TAG_W +: TAG_W];
                    buf_value_r[i] <= req_value[i*VAL_W +: VAL_W];
                end
            end
            // The old entry is read out here even if the same buffer is refilled this edge.
            if (grant_any_s) begin
                cdb_valid_r <= 1'b1;
                cdb_tag_r   <= buf_tag_r[grant_idx_s];
                cdb_value_r <= buf_value_r[grant_idx_s];
                cdb_src_r   <= grant_idx_s;
                rr_ptr_r    <= rr_next_s;
            end else begin
                cdb_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready   = req_ready_s;
    assign cdb_valid   = cdb_valid_r;
    assign cdb_tag     = cdb_tag_r;
    assign cdb_value   = cdb_value_r;
    assign cdb_src     = cdb_src_r;
    assign pending_cnt = pending_cnt_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter: a queue-based reference model
// predicts broadcasts and occupancy; a separate monitor pops and compares.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int VW = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*VW-1:0]   req_value;
    logic [N-1:0]      req_ready;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [VW-1:0]     cdb_value;
    logic [1:0]        cdb_src;
    logic [2:0]        pending_cnt;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .VAL_W(VW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_src(cdb_src), .pending_cnt(pending_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TW-1:0] tag;
        logic [VW-1:0] val;
        int            src;
    } bcast_t;

    bcast_t exp_q[$];
    int     pcnt_q[$];
    int     checks = 0;
    int     failures = 0;

    // Reference model: a slot per FU holding at most one pending result.
    bit            m_full[N];
    logic [TW-1:0] m_tag[N];
    logic [VW-1:0] m_val[N];
    int            m_rr = 0;

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [VW-1:0] v);
        req_tag[i*TW +: TW]   = t;
        req_value[i*VW +: VW] = v;
    endtask

    // Called right after inputs change at a negedge; predicts the coming posedge.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        int g;
        int cnt;
        bcast_t b;
        #1;
        if (!reset) begin
            for (int i = 0; i < N; i++) m_full[i] = 0;
            m_rr = 0;
            pcnt_q.push_back(0);
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_full[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
            for (int i = 0; i < N; i++)
                exp_ready[i] = !flush && (!m_full[i] || g == i);
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL req_ready: got %b want %b at %0t", req_ready, exp_ready, $time);
            end
            if (flush) begin
                for (int i = 0; i < N; i++) m_full[i] = 0;
            end else begin
                if (g >= 0) begin
                    b.tag = m_tag[g]; b.val = m_val[g]; b.src = g;
                    exp_q.push_back(b);
                    m_full[g] = 0;
                    m_rr = (g + 1) % N;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && exp_ready[i]) begin
                        m_full[i] = 1;
                        m_tag[i]  = req_tag[i*TW +: TW];
                        m_val[i]  = req_value[i*VW +: VW];
                    end
                end
            end
            cnt = 0;
            for (int i = 0; i < N; i++) cnt += int'(m_full[i]);
            pcnt_q.push_back(cnt);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            req_valid = '0;
            flush = 1'b0;
            cycle();
        end
    endtask

    // Monitor: compares whatever the DUT broadcast after each edge against the scoreboard.
    always @(negedge clock) begin
        bcast_t e;
        int p;
        if (cdb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_bcast: got tag %0d src %0d, want no broadcast", cdb_tag, cdb_src);
            end else begin
                e = exp_q.pop_front();
                if (cdb_tag !== e.tag || cdb_value !== e.val || int'(cdb_src) != e.src) begin
                    failures++;
                    $display("FAIL bcast: got tag %0d val %h src %0d want tag %0d val %h src %0d",
                             cdb_tag, cdb_value, cdb_src, e.tag, e.val, e.src);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL missing_bcast: got cdb_valid %b want tag %0d src %0d", cdb_valid, e.tag, e.src);
        end
        if (pcnt_q.size() != 0) begin
            p = pcnt_q.pop_front();
            checks++;
            if (int'(pending_cnt) != p) begin
                failures++;
                $display("FAIL pending_cnt: got %0d want %0d at %0t", pending_cnt, p, $time);
            end
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_value = '0;
        @(negedge clock);

        // Reset held two edges with every FU requesting.
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, TW'(i + 1), VW'(64'hAA));
        cycle();
        cycle();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid %b tag %0d val %h src %0d want all zero",
                     cdb_valid, cdb_tag, cdb_value, cdb_src);
        end
        reset = 1'b1; req_valid = '0;
        cycle();
        idle(1);

        // Single request from FU 2.
        req_valid = 4'b0100; set_req(2, 6'd3, 64'h10);
        cycle();
        idle(3);

        // Contention: all four FUs at once.
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, TW'(10 + i), VW'(64'h100 + 64'(i)));
        cycle();
        idle(6);

        // Wrap: FU 2 moves the pointer to 3, then buffers 0 and 3 fill together.
        req_valid = 4'b0100; set_req(2, 6'd40, 64'h40);
        cycle();
        req_valid = 4'b1001; set_req(0, 6'd41, 64'h41); set_req(3, 6'd42, 64'h42);
        cycle();
        idle(4);

        // Flush while buffers 0..2 hold tags 5, 6, 7.
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) set_req(i, TW'(5 + i), VW'(64'h50 + 64'(i)));
        cycle();
        req_valid = '0; flush = 1'b1;
        cycle();
        idle(3);

        // Streaming from FU 1.
        for (int t = 20; t < 24; t++) begin
            req_valid = 4'b0010; set_req(1, TW'(t), VW'(t) << 8);
            cycle();
        end
        idle(3);

        // Random traffic with occasional flush and mid-run reset.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            flush = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
            req_valid = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                set_req(i, TW'($urandom_range(0, 63)), {$urandom, $urandom});
            cycle();
        end
        reset = 1'b1;
        idle(8);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d undelivered broadcasts want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
